// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, coordinate/colour types and the colour-bar table
// shared by the VGA scan controller and its delay line.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE   = 640;
   localparam int unsigned DEF_H_FP       = 16;
   localparam int unsigned DEF_H_SYNC     = 96;
   localparam int unsigned DEF_H_BP       = 48;
   localparam int unsigned DEF_V_ACTIVE   = 480;
   localparam int unsigned DEF_V_FP       = 10;
   localparam int unsigned DEF_V_SYNC     = 2;
   localparam int unsigned DEF_V_BP       = 33;
   localparam int unsigned DEF_PIPE_DELAY = 2;

   localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int unsigned COORD_W   = 11;
   localparam int unsigned CHAN_W    = 8;
   localparam int unsigned BAR_WIDTH = 80;
   localparam int unsigned BAR_IDX_W = 3;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic [CHAN_W-1:0] red;
      logic [CHAN_W-1:0] green;
      logic [CHAN_W-1:0] blue;
   } rgb24_t;

   // Per-pixel timing flags carried alongside the colour pipeline
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{active: 1'b0, hs: 1'b0, vs: 1'b0};

   // White, yellow, cyan, green, magenta, red, blue, black
   localparam rgb24_t BAR_TABLE [8] = '{
      '{red: 8'hFF, green: 8'hFF, blue: 8'hFF},
      '{red: 8'hFF, green: 8'hFF, blue: 8'h00},
      '{red: 8'h00, green: 8'hFF, blue: 8'hFF},
      '{red: 8'h00, green: 8'hFF, blue: 8'h00},
      '{red: 8'hFF, green: 8'h00, blue: 8'hFF},
      '{red: 8'hFF, green: 8'h00, blue: 8'h00},
      '{red: 8'h00, green: 8'h00, blue: 8'hFF},
      '{red: 8'h00, green: 8'h00, blue: 8'h00}
   };

endpackage

// File: rtl/sync_delay_line.sv
// Depth-N shift register for the {active, hs, vs} flags; resets every stage to idle.
module sync_delay_line
   import vga_timing_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_PIPE_DELAY
) (
   input  logic  clk,
   input  logic  resetN,
   input  sync_t d,
   output sync_t q
);

   sync_t stage [DEPTH];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < int'(DEPTH); i++) stage[i] <= SYNC_IDLE;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_controller.sv
// 640x480@60 raster generator: pixel counters out, aligned DAC colour/sync/blank back.
// Optional VGA_TEST_PATTERN_EN adds testPatternN, which replaces colour with 8 vertical bars.
module vga_scan_controller
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic [CHAN_W-1:0] redIn,
   input  logic [CHAN_W-1:0] greenIn,
   input  logic [CHAN_W-1:0] blueIn,
`ifdef VGA_TEST_PATTERN_EN
   input  logic              testPatternN,
`endif
   output coord_t            pixelX,
   output coord_t            pixelY,
   output logic              startOfFrame,
   output logic [CHAN_W-1:0] redOut,
   output logic [CHAN_W-1:0] greenOut,
   output logic [CHAN_W-1:0] blueOut,
   output logic              hSyncN,
   output logic              vSyncN,
   output logic              blankN
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST     = COORD_W'(H_TOTAL - 1);
   localparam coord_t V_LAST     = COORD_W'(V_TOTAL - 1);
   localparam coord_t H_VIS      = COORD_W'(H_ACTIVE);
   localparam coord_t V_VIS      = COORD_W'(V_ACTIVE);
   localparam coord_t HS_START   = COORD_W'(H_ACTIVE + H_FP);
   localparam coord_t HS_END     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_START   = COORD_W'(V_ACTIVE + V_FP);
   localparam coord_t VS_END     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   coord_t h_count;
   coord_t v_count;
   sync_t  sync_now_c;
   sync_t  sync_dly;
   rgb24_t pix_c;

   // Raster counters; vertical advances on the horizontal wrap
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_count == H_LAST) begin
         h_count <= '0;
         v_count <= (v_count == V_LAST) ? '0 : v_count + COORD_W'(1);
      end else begin
         h_count <= h_count + COORD_W'(1);
      end
   end

   assign pixelX       = h_count;
   assign pixelY       = v_count;
   assign startOfFrame = (h_count == '0) && (v_count == '0);

   always_comb begin
      sync_now_c        = SYNC_IDLE;
      sync_now_c.active = (h_count < H_VIS) && (v_count < V_VIS);
      sync_now_c.hs     = (h_count >= HS_START) && (h_count < HS_END);
      sync_now_c.vs     = (v_count >= VS_START) && (v_count < VS_END);
   end

   sync_delay_line #(
      .DEPTH (PIPE_DELAY)
   ) u_sync_delay_line (
      .clk    (clk),
      .resetN (resetN),
      .d      (sync_now_c),
      .q      (sync_dly)
   );

`ifdef VGA_TEST_PATTERN_EN
   // Bar index rides its own delay line so it lines up with the delayed flags
   logic [BAR_IDX_W-1:0] bar_now_c;
   logic [BAR_IDX_W-1:0] bar_dly [PIPE_DELAY];

   assign bar_now_c = BAR_IDX_W'(h_count / COORD_W'(BAR_WIDTH));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < int'(PIPE_DELAY); i++) bar_dly[i] <= '0;
      end else begin
         bar_dly[0] <= bar_now_c;
         for (int i = 1; i < int'(PIPE_DELAY); i++) bar_dly[i] <= bar_dly[i-1];
      end
   end
`endif

   always_comb begin
      pix_c = '{red: redIn, green: greenIn, blue: blueIn};
`ifdef VGA_TEST_PATTERN_EN
      if (!testPatternN) pix_c = BAR_TABLE[bar_dly[PIPE_DELAY-1]];
`endif
   end

   // DAC output register: colour gated to black outside the visible area
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         redOut   <= '0;
         greenOut <= '0;
         blueOut  <= '0;
         hSyncN   <= 1'b1;
         vSyncN   <= 1'b1;
         blankN   <= 1'b0;
      end else begin
         redOut   <= sync_dly.active ? pix_c.red   : '0;
         greenOut <= sync_dly.active ? pix_c.green : '0;
         blueOut  <= sync_dly.active ? pix_c.blue  : '0;
         hSyncN   <= ~sync_dly.hs;
         vSyncN   <= ~sync_dly.vs;
         blankN   <= sync_dly.active;
      end
   end

endmodule
